// File: rtl/rb_dump_unit_pkg.sv
// Shared definitions for the register-bank dump unit: FSM encoding and
// word/byte geometry helpers.
package rb_dump_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } dump_state_t;

    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(32, 8);

endpackage

// File: rtl/rb_dump_unit_serializer.sv
// Holds one bank word and presents it a byte at a time, most significant
// byte first, with a flag marking the final byte of the word.
module word_byte_serializer
    import rb_dump_unit_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_advance,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_last
);

    localparam int BPW    = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BPW - 1);

    logic [NB_DATA-1:0] r_word;
    logic [NB_CNT-1:0]  r_cnt;
    logic [NB_DATA-1:0] w_shifted;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_cnt  <= '0;
        end else if (i_advance && !o_last) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Left-shift brings the selected byte to the top, giving MSB-first order.
    assign w_shifted = r_word << (r_cnt * NB_BYTE);
    assign o_byte    = w_shifted[NB_DATA-1 -: NB_BYTE];
    assign o_last    = (r_cnt == LAST_CNT);

endmodule

// File: rtl/rb_dump_unit.sv
// Dumps the whole register bank over a byte-wide ready/valid stream:
// FSM plus register index counter; byte handling lives in the serializer.
module rb_dump_unit
    import rb_dump_unit_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 5,
    parameter int BANK_DEPTH = 32,
    parameter int NB_BYTE    = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    output logic               o_rb_enable,
    output logic               o_rb_read_enable,
    output logic [NB_ADDR-1:0] o_rb_read_address,
    input  logic [NB_DATA-1:0] i_rb_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(BANK_DEPTH - 1);

    dump_state_t        r_state;
    dump_state_t        w_next_state;
    logic [NB_ADDR-1:0] r_index;
    logic               w_idx_clr;
    logic               w_idx_inc;
    logic               w_load;
    logic               w_advance;
    logic               w_last;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_index <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_idx_clr) begin
                r_index <= '0;
            end else if (w_idx_inc) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_idx_clr        = 1'b0;
        w_idx_inc        = 1'b0;
        w_load           = 1'b0;
        w_advance        = 1'b0;
        o_rb_enable      = 1'b0;
        o_rb_read_enable = 1'b0;
        o_tx_valid       = 1'b0;
        o_done           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_idx_clr    = 1'b1;
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                o_rb_enable      = 1'b1;
                o_rb_read_enable = 1'b1;
                w_next_state     = ST_LATCH;
            end
            ST_LATCH: begin
                w_load       = 1'b1;
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                o_tx_valid = 1'b1;
                if (i_tx_ready) begin
                    if (!w_last) begin
                        w_advance = 1'b1;
                    end else if (r_index == LAST_IDX) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_idx_inc    = 1'b1;
                        w_next_state = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Address comes straight from the index register, so it holds in every state.
    assign o_rb_read_address = r_index;
    assign o_busy            = (r_state != ST_IDLE);

    word_byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_load    (w_load),
        .i_word    (i_rb_data),
        .i_advance (w_advance),
        .o_byte    (o_tx_data),
        .o_last    (w_last)
    );

endmodule

// File: tb/tb_rb_dump_unit.sv
// Directed bench for rb_dump_unit: models a synchronous-read register bank
// and checks the byte stream, handshake timing, restart and reset behaviour.
module tb_rb_dump_unit;

    localparam int NB_DATA    = 32;
    localparam int NB_ADDR    = 5;
    localparam int BANK_DEPTH = 32;
    localparam int NB_BYTE    = 8;
    localparam int NBYTES     = BANK_DEPTH * NB_DATA / NB_BYTE;
    localparam int BUDGET     = 3000;

    logic               clk = 1'b0;
    logic               i_reset;
    logic               i_start;
    logic               i_tx_ready;
    logic [NB_DATA-1:0] rb_data;
    logic               o_rb_enable;
    logic               o_rb_read_enable;
    logic [NB_ADDR-1:0] o_rb_read_address;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               o_busy;
    logic               o_done;

    logic [NB_DATA-1:0] bank [BANK_DEPTH];

    int tests = 0;
    int fails = 0;
    int got_bytes;
    int got_done;
    int last_hs;
    int done_it;

    always #5 clk = ~clk;

    rb_dump_unit #(
        .NB_DATA    (NB_DATA),
        .NB_ADDR    (NB_ADDR),
        .BANK_DEPTH (BANK_DEPTH),
        .NB_BYTE    (NB_BYTE)
    ) dut (
        .i_clock           (clk),
        .i_reset           (i_reset),
        .i_start           (i_start),
        .o_rb_enable       (o_rb_enable),
        .o_rb_read_enable  (o_rb_read_enable),
        .o_rb_read_address (o_rb_read_address),
        .i_rb_data         (rb_data),
        .o_tx_data         (o_tx_data),
        .o_tx_valid        (o_tx_valid),
        .i_tx_ready        (i_tx_ready),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    // Bank model: data appears the cycle after an enabled read request.
    always @(posedge clk) begin
        if (o_rb_enable && o_rb_read_enable) rb_data <= bank[o_rb_read_address];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int n);
        logic [31:0] w;
        w = bank[n / 4];
        return 8'(w >> (24 - 8 * (n % 4)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rb_en"}, o_rb_enable, 0);
        check({pfx, "_rb_rden"}, o_rb_read_enable, 0);
        check({pfx, "_addr"}, o_rb_read_address, 0);
        check({pfx, "_txdata"}, o_tx_data, 0);
        check({pfx, "_txvalid"}, o_tx_valid, 0);
        check({pfx, "_busy"}, o_busy, 0);
        check({pfx, "_done"}, o_done, 0);
    endtask

    // mode 0: ready always high; mode 1: ready high one cycle in three.
    task automatic run_dump(input int mode, input int restart_at, input int reset_at);
        int          nb = 0;
        int          it = 0;
        bit          restarted = 1'b0;
        bit          stalled = 1'b0;
        logic [7:0]  held = '0;
        got_done = 0;
        last_hs  = -1;
        done_it  = -1;
        while (it < BUDGET) begin
            i_start = (it == 0);
            if (!restarted && restart_at >= 0 && nb == restart_at) begin
                i_start   = 1'b1;
                restarted = 1'b1;
            end
            i_tx_ready = (mode == 0) ? 1'b1 : (it % 3 == 0);
            if (stalled) begin
                check($sformatf("stall_data_b%0d", nb), o_tx_data, held);
                check($sformatf("stall_valid_b%0d", nb), o_tx_valid, 1);
            end
            stalled = o_tx_valid && !i_tx_ready;
            held    = o_tx_data;
            if (o_done) begin
                got_done++;
                if (done_it < 0) done_it = it;
            end
            if (o_tx_valid && i_tx_ready) begin
                if (nb < NBYTES) check($sformatf("byte%0d", nb), o_tx_data, exp_byte(nb));
                nb++;
                last_hs = it;
            end
            if (reset_at >= 0 && nb == reset_at) begin
                i_reset = 1'b1;
                i_start = 1'b0;
                tick();
                i_reset = 1'b0;
                check_reset_outputs("abort");
                got_bytes = nb;
                return;
            end
            if (done_it >= 0 && it > done_it + 3) break;
            tick();
            it++;
        end
        i_start = 1'b0;
        check("dump_completed", (done_it >= 0), 1);
        got_bytes = nb;
    endtask

    initial begin
        for (int k = 0; k < BANK_DEPTH; k++) bank[k] = 32'h1000_0000 + k;
        rb_data    = '0;
        i_reset    = 1'b1;
        i_start    = 1'b1;
        i_tx_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        i_reset = 1'b0;
        i_start = 1'b0;
        tick();

        // Handshake timing: start in cycle 0, REQ in cycle 1, first byte in cycle 3.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("t1_rb_en", o_rb_enable, 1);
        check("t1_rb_rden", o_rb_read_enable, 1);
        check("t1_addr", o_rb_read_address, 0);
        check("t1_busy", o_busy, 1);
        check("t1_txvalid", o_tx_valid, 0);
        tick();
        check("t2_rb_en", o_rb_enable, 0);
        check("t2_txvalid", o_tx_valid, 0);
        tick();
        check("t3_txvalid", o_tx_valid, 1);
        check("t3_txdata", o_tx_data, 8'h10);
        check("t3_rb_en", o_rb_enable, 0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_reset_outputs("t_abort");

        // Full dump, ready always high.
        run_dump(0, -1, -1);
        check("full_bytes", got_bytes, NBYTES);
        check("full_done", got_done, 1);
        check("full_busy_after", o_busy, 0);
        check("full_addr_after", o_rb_read_address, BANK_DEPTH - 1);

        // Back-pressure: ready one cycle in three.
        run_dump(1, -1, -1);
        check("stall_bytes", got_bytes, NBYTES);
        check("stall_done", got_done, 1);
        check("stall_busy_after", o_busy, 0);

        // Start pulse mid-dump is ignored.
        run_dump(0, 40, -1);
        check("restart_bytes", got_bytes, NBYTES);
        check("restart_done", got_done, 1);

        // Reset mid-dump abandons it; the next dump begins at reg[0] byte 0.
        run_dump(0, -1, 70);
        check("abort_bytes", got_bytes, 70);
        check("abort_no_done", got_done, 0);
        run_dump(0, -1, -1);
        check("after_abort_bytes", got_bytes, NBYTES);
        check("after_abort_done", got_done, 1);

        // Distinct final word; done follows the last accepted byte by one cycle.
        bank[31] = 32'hDEAD_BEEF;
        run_dump(0, -1, -1);
        check("beef_bytes", got_bytes, NBYTES);
        check("beef_done", got_done, 1);
        check("beef_done_timing", done_it, last_hs + 1);
        repeat (5) tick();
        check("beef_addr_hold", o_rb_read_address, 31);
        check("beef_busy", o_busy, 0);
        check("beef_done_low", o_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
